ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/ram_arbiter_if.sv | 41 ++++
 rtl/ram_arbiter_arb2_rr.sv | 37 +++
 rtl/ram_arbiter.sv | 101 ++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: default widths, port id type and in-flight read tag shared by the arbiter files
package ram_arbiter_pkg;

    localparam int ADDR_W_DFLT = 8;
    localparam int DATA_W_DFLT = 64;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two requester ports plus the single-port RAM command/response bus
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              ram_cen;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output ram_cen, ram_wen, ram_addr, ram_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  ram_cen, ram_wen, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_arbiter_arb2_rr.sv
// arb2_rr: combinational 2-way grant; round-robin when RAM_ARBITER_RR_EN is defined, port0 priority otherwise
module arb2_rr
    import ram_arbiter_pkg::*;
(
`ifdef RAM_ARBITER_RR_EN
    input  logic clk,
`endif
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

`ifdef RAM_ARBITER_RR_EN
    port_id_t last;

    // Remember the port granted on each accepting edge; reset leaves port1 as last so port0 wins first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last <= 1'b1;
        else if (gnt0 | gnt1) last <= gnt1;
    end

    // On conflict port0 wins only when port1 was granted most recently
    always_comb begin
        gnt0 = reset_n && req0 && (!req1 || last);
        gnt1 = reset_n && req1 && !gnt0;
    end
`else
    // Port0 always wins a conflict; grants are suppressed during reset
    always_comb begin
        gnt0 = reset_n && req0;
        gnt1 = reset_n && req1 && !req0;
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters onto one synchronous single-port RAM, one access per cycle, reads return 2 edges after accept
// Optional feature: define RAM_ARBITER_RR_EN for round-robin conflict resolution (default is fixed port0 priority).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input logic          clk,
    input logic          reset_n,
    ram_arbiter_if.slave bus
);

    logic              gnt0;
    logic              gnt1;
    logic              acc;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              cen_q;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    tag_t              tag0;
    tag_t              tag1;

    arb2_rr u_arb (
`ifdef RAM_ARBITER_RR_EN
        .clk     (clk),
`endif
        .reset_n (reset_n),
        .req0    (bus.req0),
        .req1    (bus.req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign acc      = gnt0 | gnt1;
    assign win_we   = gnt1 ? bus.we1 : bus.we0;
    assign win_addr = gnt1 ? bus.addr1 : bus.addr0;
    assign win_data = gnt1 ? bus.wdata1 : bus.wdata0;

    // Register the winner's command; without an accept only the enable drops, the rest holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cen_q  <= 1'b0;
            wen_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            cen_q <= acc;
            if (acc) begin
                wen_q  <= win_we;
                addr_q <= win_addr;
                din_q  <= win_data;
            end
        end
    end

    // Two-stage tag follows each read through the RAM so its data is steered to the right port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag0 <= '0;
            tag1 <= '0;
        end else begin
            tag0 <= '{valid: acc && !win_we, port: gnt1};
            tag1 <= tag0;
        end
    end

    // Capture RAM read data into the owning port and pulse its rvalid; other port's data holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= tag1.valid && !tag1.port;
            rvalid1_q <= tag1.valid && tag1.port;
            if (tag1.valid && !tag1.port) rdata0_q <= bus.ram_dout;
            if (tag1.valid && tag1.port) rdata1_q <= bus.ram_dout;
        end
    end

    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.ram_cen  = cen_q;
    assign bus.ram_wen  = wen_q;
    assign bus.ram_addr = addr_q;
    assign bus.ram_din  = din_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random stimulus against a memory-map / response-schedule reference model
module tb_ram_arbiter;

`ifdef RAM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        int          due;
        logic [63:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    logic [63:0] ram     [256];
    logic [63:0] ref_mem [256];
    rsp_t        q0[$];
    rsp_t        q1[$];
    logic        last;
    logic        e0;
    logic        e1;
    logic        g0_obs;
    logic        g1_obs;
    logic        exp_cen;
    logic        exp_wen;
    logic [7:0]  exp_addr;
    logic [63:0] exp_din;
    logic [63:0] exp_rd0;
    logic [63:0] exp_rd1;
    logic [3:0]  hist0;
    logic [3:0]  hist1;
    logic [5:0]  rv;
    logic        act;

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(64)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_cen && bus.ram_wen) ram[bus.ram_addr] = bus.ram_din;
        if (bus.ram_cen && !bus.ram_wen) bus.ram_dout <= ram[bus.ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        p;
        logic        w;
        logic [7:0]  a;
        logic [63:0] d;
        logic        v0;
        logic        v1;
        @(negedge clk);
        e0 = reset_n && bus.req0 && (!bus.req1 || !RR || last);
        e1 = reset_n && bus.req1 && !e0;
        g0_obs = bus.gnt0;
        g1_obs = bus.gnt1;
        chk("gnt0", g0_obs, e0);
        chk("gnt1", g1_obs, e1);
        exp_cen = e0 | e1;
        if (exp_cen) begin
            p = e1;
            w = p ? bus.we1 : bus.we0;
            a = p ? bus.addr1 : bus.addr0;
            d = p ? bus.wdata1 : bus.wdata0;
            exp_wen = w;
            exp_addr = a;
            exp_din = d;
            last = p;
            if (w) ref_mem[a] = d;
            else if (p) q1.push_back('{due: cyc + 3, data: ref_mem[a]});
            else q0.push_back('{due: cyc + 3, data: ref_mem[a]});
        end
        @(posedge clk);
        cyc++;
        #1;
        chk("ram_cen", bus.ram_cen, exp_cen);
        chk("ram_wen", bus.ram_wen, exp_wen);
        chk("ram_addr", bus.ram_addr, exp_addr);
        chk("ram_din", bus.ram_din, exp_din);
        v0 = q0.size() > 0 && q0[0].due == cyc;
        v1 = q1.size() > 0 && q1[0].due == cyc;
        if (v0) begin
            exp_rd0 = q0[0].data;
            void'(q0.pop_front());
        end
        if (v1) begin
            exp_rd1 = q1[0].data;
            void'(q1.pop_front());
        end
        chk("rvalid0", bus.rvalid0, v0);
        chk("rvalid1", bus.rvalid1, v1);
        chk("rdata0", bus.rdata0, exp_rd0);
        chk("rdata1", bus.rdata1, exp_rd1);
    endtask

    task automatic do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.we0 = 1'b0;
        bus.we1 = 1'b0;
        reset_n = 1'b0;
        q0.delete();
        q1.delete();
        last = 1'b1;
        exp_wen = 1'b0;
        exp_addr = '0;
        exp_din = '0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        #1;
        chk("rst_gnt0", bus.gnt0, 1'b0);
        chk("rst_gnt1", bus.gnt1, 1'b0);
        chk("rst_ram_cen", bus.ram_cen, 1'b0);
        chk("rst_ram_wen", bus.ram_wen, 1'b0);
        chk("rst_ram_addr", bus.ram_addr, 8'h00);
        chk("rst_ram_din", bus.ram_din, 64'h0);
        chk("rst_rvalid0", bus.rvalid0, 1'b0);
        chk("rst_rvalid1", bus.rvalid1, 1'b0);
        chk("rst_rdata0", bus.rdata0, 64'h0);
        chk("rst_rdata1", bus.rdata1, 64'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] = 64'h0123_4567_89AB_0000 + 64'(i);
            ref_mem[i] = 64'h0123_4567_89AB_0000 + 64'(i);
        end
        bus.addr0 = '0;
        bus.addr1 = '0;
        bus.wdata0 = '0;
        bus.wdata1 = '0;
        e0 = 1'b0;
        e1 = 1'b0;
        #2;
        do_reset();
        tick();
        tick();
        // single write then read on port0
        bus.req0 = 1'b1;
        bus.req1 = 1'b0;
        bus.we0 = 1'b1;
        bus.addr0 = 8'h01;
        bus.wdata0 = 64'h0000_0000_0000_FFFF;
        reset_n = 1'b1;
        tick();
        bus.we0 = 1'b0;
        tick();
        bus.req0 = 1'b0;
        tick();
        tick();
        tick();
        chk("wr_rd_rdata0", bus.rdata0, 64'h0000_0000_0000_FFFF);
        // write on port0 then read of the same address on port1 the next edge
        bus.req0 = 1'b1;
        bus.we0 = 1'b1;
        bus.addr0 = 8'h02;
        bus.wdata0 = 64'hFFFF_FFFF_0000_0000;
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1;
        bus.we1 = 1'b0;
        bus.addr1 = 8'h02;
        tick();
        bus.req1 = 1'b0;
        tick();
        tick();
        tick();
        chk("hazard_rdata1", bus.rdata1, 64'hFFFF_FFFF_0000_0000);
        // held conflict, both reading
        bus.req0 = 1'b1;
        bus.we0 = 1'b0;
        bus.addr0 = 8'h00;
        bus.req1 = 1'b1;
        bus.addr1 = 8'h02;
        for (int i = 0; i < 4; i++) begin
            tick();
            hist0[i] = g0_obs;
            hist1[i] = g1_obs;
        end
        chk("conflict_gnt0_seq", hist0, RR ? 4'b0101 : 4'b1111);
        chk("conflict_gnt1_seq", hist1, RR ? 4'b1010 : 4'b0000);
        bus.req0 = 1'b0;
        tick();
        bus.req1 = 1'b0;
        tick();
        tick();
        tick();
        // back-to-back reads on port1
        bus.we1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.req1 = (i < 3);
            bus.addr1 = 8'(i);
            tick();
            rv[i] = bus.rvalid1;
        end
        chk("b2b_rvalid1_seq", rv, 6'b011100);
        // idle
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            act = act | bus.ram_cen | g0_obs | g1_obs | bus.rvalid0 | bus.rvalid1;
        end
        chk("idle_activity", act, 1'b0);
        // random traffic, requests held until granted
        for (int i = 0; i < 400; i++) begin
            if (!bus.req0 || e0) begin
                bus.req0 = ($urandom_range(0, 2) != 0);
                bus.we0 = ($urandom_range(0, 1) != 0);
                bus.addr0 = 8'($urandom_range(0, 7));
                bus.wdata0 = {$urandom, $urandom};
            end
            if (!bus.req1 || e1) begin
                bus.req1 = ($urandom_range(0, 2) != 0);
                bus.we1 = ($urandom_range(0, 1) != 0);
                bus.addr1 = 8'($urandom_range(0, 7));
                bus.wdata1 = {$urandom, $urandom};
            end
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        // reset one cycle after a port0 read accept
        bus.req0 = 1'b1;
        bus.we0 = 1'b0;
        bus.addr0 = 8'h05;
        tick();
        bus.req0 = 1'b0;
        tick();
        do_reset();
        tick();
        tick();
        bus.addr0 = 8'h00;
        bus.addr1 = 8'h02;
        reset_n = 1'b1;
        tick();
        chk("post_reset_conflict_gnt0", g0_obs, 1'b1);
        bus.req0 = 1'b0;
        tick();
        bus.req1 = 1'b0;
        tick();
        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
